// File: rtl/checkbits_seq_monitor.sv
// Checkpoint-sequence monitor: waits for START_CODE, then the programmed table values in order, then END_CODE.
// Optional per-step watchdog enabled by defining CHK_TIMEOUT_EN.
module checkbits_seq_monitor #(
    parameter int                 WIDTH      = 16,
    parameter int                 DEPTH      = 16,
    parameter int                 TO_W       = 24,
    parameter logic [WIDTH-1:0]   START_CODE = 16'hAB40,
    parameter logic [WIDTH-1:0]   END_CODE   = 16'hAB51,
    localparam int                AW         = $clog2(DEPTH)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [WIDTH-1:0]   chk_i,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [WIDTH-1:0]   cfg_data,
    input  logic [AW:0]        cfg_len,
    input  logic               arm,
    input  logic [TO_W-1:0]    timeout_cycles,
    output logic               busy,
    output logic               match_pulse,
    output logic [AW:0]        idx,
    output logic               done,
    output logic               pass,
    output logic               fail
);

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_CHECK,
        S_WAIT_END,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_chk_q;
    logic [WIDTH-1:0]   r_tbl [DEPTH];
    logic [AW:0]        r_len;
    logic [AW:0]        r_idx;
    logic               r_busy;
    logic               r_mp;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;

    logic [AW:0]        w_len_clamp;
    logic [AW:0]        w_idx_nx;
    logic               w_start_hit;
    logic               w_end_hit;
    logic               w_tbl_hit;
    logic               w_adv;
    logic               w_to;

    assign w_len_clamp = (cfg_len > L_DEPTH) ? L_DEPTH : cfg_len;
    assign w_idx_nx    = r_idx + L_ONE;
    assign w_start_hit = (r_chk_q == START_CODE);
    assign w_end_hit   = (r_chk_q == END_CODE);
    assign w_tbl_hit   = (r_chk_q == r_tbl[r_idx[AW-1:0]]);

    // Any forward progress of a run restarts the watchdog.
    assign w_adv = ((r_state == S_WAIT_START) && w_start_hit) ||
                   ((r_state == S_CHECK)      && w_tbl_hit)   ||
                   ((r_state == S_WAIT_END)   && w_end_hit);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_chk_q <= '0;
        else          r_chk_q <= chk_i;
    end

    // Table survives reset so firmware can program it once and re-run.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we) r_tbl[cfg_addr] <= cfg_data;
    end

`ifdef CHK_TIMEOUT_EN
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nx;

    assign w_cnt_nx = r_cnt + TO_W'(1);
    assign w_to     = r_busy && !w_adv && (timeout_cycles != '0) && (w_cnt_nx == timeout_cycles);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !r_busy || w_adv) r_cnt <= '0;
        else                              r_cnt <= w_cnt_nx;
    end
`else
    logic w_unused_to;
    assign w_unused_to = ^timeout_cycles;
    assign w_to        = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_mp    <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_mp <= 1'b0;
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (arm) begin
                        r_state <= S_WAIT_START;
                        r_busy  <= 1'b1;
                        r_len   <= w_len_clamp;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                S_WAIT_START: begin
                    if (w_start_hit) begin
                        r_state <= (r_len == '0) ? S_WAIT_END : S_CHECK;
                    end else if (w_to) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fail  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    // Non-matching values are simply waited through.
                    if (w_tbl_hit) begin
                        r_mp  <= 1'b1;
                        r_idx <= w_idx_nx;
                        if (w_idx_nx == r_len) r_state <= S_WAIT_END;
                    end else if (w_to) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fail  <= 1'b1;
                    end
                end
                S_WAIT_END: begin
                    if (w_end_hit) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (w_to) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_fail  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign match_pulse = r_mp;
    assign idx         = r_idx;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Bench for checkbits_seq_monitor: directed plan scenarios plus randomized runs against a sequence-level model.
module tb_checkbits_seq_monitor;

    localparam int          D   = 16;
    localparam logic [15:0] STC = 16'hAB40;
    localparam logic [15:0] ENC = 16'hAB51;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [15:0] chk_i = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic [4:0]  cfg_len = '0;
    logic        arm = 1'b0;
    logic [23:0] timeout_cycles = '0;
    logic        busy, match_pulse, done, pass, fail;
    logic [4:0]  idx;

    int errors = 0;
    int checks = 0;
    int mp_total = 0;

    logic [15:0] plan [10];
    logic [15:0] tbl_m [D];

    checkbits_seq_monitor dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .chk_i(chk_i),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .arm(arm), .timeout_cycles(timeout_cycles),
        .busy(busy), .match_pulse(match_pulse), .idx(idx),
        .done(done), .pass(pass), .fail(fail)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) if (match_pulse === 1'b1) mp_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drv(input logic [15:0] v);
        chk_i = v;
        tick();
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
        tick();
        cfg_we = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
    endtask

    task automatic do_arm(input int len);
        cfg_len = 5'(len);
        chk_i = 16'h0000;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Sequence-level reference: walk the observed values through start / ordered entries / end.
    task automatic model(input logic [15:0] seq[$], input int len, output int ph, output int k);
        int n;
        n = (len > D) ? D : len;
        ph = 0; k = 0;
        foreach (seq[i]) begin
            if (ph == 0) begin
                if (seq[i] == STC) ph = (n == 0) ? 2 : 1;
            end else if (ph == 1) begin
                if (seq[i] == tbl_m[k]) begin
                    k++;
                    if (k == n) ph = 2;
                end
            end else if (ph == 2) begin
                if (seq[i] == ENC) ph = 3;
            end
        end
    endtask

    task automatic load_plan();
        for (int i = 0; i < 10; i++) wr(i, plan[i]);
    endtask

    task automatic run_plan(input string tag, input bit early_893);
        int mp0;
        mp0 = mp_total;
        do_arm(10);
        chk(tag, {done, pass, fail, busy}, 4'b0001);
        drv(STC);
        if (early_893) drv(16'd893);
        for (int i = 0; i < 10; i++) begin
            drv(16'h7000 + 16'(i));
            drv(plan[i]);
        end
        drv(ENC);
        drv(16'h0000);
        tick();
        #6;
        chk(tag, 32'(mp_total - mp0), 32'd10);
        chk(tag, 32'(idx), 32'd10);
        chk(tag, {done, pass, fail, busy}, 4'b1100);
    endtask

    initial begin
        logic [15:0] seq[$];
        int ph, k, len, mp0;
        plan = '{16'd40, 16'd893, 16'd2541, 16'd2669, 16'd3233,
                 16'd4267, 16'd4622, 16'd5681, 16'd6023, 16'd9073};

        tick(); tick();
        chk("reset_state", {busy, match_pulse, idx, done, pass, fail}, 10'b0);
        wb_rst_i = 1'b0;

        load_plan();
        run_plan("plan_in_order", 1'b0);
        run_plan("plan_893_first_rearm", 1'b1);

        // Empty list: start then end, no entry matches.
        do_reset();
        mp0 = mp_total;
        do_arm(0);
        drv(STC); drv(16'd40); drv(ENC); drv(16'h0); tick(); #6;
        chk("len0_pass", {done, pass, fail, busy}, 4'b1100);
        chk("len0_no_match", 32'(mp_total - mp0), 32'd0);

        // Held value equal to two consecutive entries matches once per cycle.
        do_reset();
        wr(0, 16'd40); wr(1, 16'd40);
        do_arm(2);
        drv(STC);
        chk_i = 16'd40;
        tick(); chk("hold_c0", {match_pulse, idx}, {1'b0, 5'd0});
        tick(); chk("hold_c1", {match_pulse, idx}, {1'b1, 5'd1});
        tick(); chk("hold_c2", {match_pulse, idx}, {1'b1, 5'd2});
        tick(); chk("hold_c3", {match_pulse, busy}, 2'b01);
        drv(ENC); tick();
        chk("hold_end", {done, pass}, 2'b11);

        // Reset in the middle of CHECK, then a full run.
        load_plan();
        do_reset();
        do_arm(10);
        drv(STC);
        for (int i = 0; i < 5; i++) drv(plan[i]);
        chk_i = 16'h0; tick(); tick();
        chk("midrun_idx5", {busy, idx}, {1'b1, 5'd5});
        wb_rst_i = 1'b1; tick();
        chk("midrun_reset", {busy, idx, done, pass, fail}, 9'b0);
        wb_rst_i = 1'b0;
        run_plan("after_reset_run", 1'b0);

        // Stall after the third entry.
        do_reset();
        timeout_cycles = 24'd100;
        do_arm(10);
        drv(STC);
        for (int i = 0; i < 3; i++) drv(plan[i]);
        chk_i = 16'h0; tick();
        chk("stall_match3", {match_pulse, idx}, {1'b1, 5'd3});
`ifdef CHK_TIMEOUT_EN
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 99) chk("to_not_yet", {fail, busy}, 2'b01);
        end
        chk("to_fire", {done, pass, fail, busy, idx}, {4'b1010, 5'd3});
`else
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_while_busy", {busy, idx}, {1'b1, 5'd3});
        for (int i = 0; i < 150; i++) tick();
        chk("stall_forever", {done, pass, fail, busy, idx}, {4'b0001, 5'd3});
`endif
        timeout_cycles = 24'd0;

        // Randomized runs, including lengths that clamp to DEPTH.
        for (int r = 0; r < 24; r++) begin
            do_reset();
            for (int i = 0; i < D; i++) begin
                logic [15:0] v;
                v = 16'($urandom_range(0, 31)) + 16'h100;
                wr(i, v);
            end
            len = (r == 0) ? 20 : $urandom_range(0, 18);
            seq.delete();
            if ($urandom_range(0, 9) != 0) seq.push_back(STC);
            for (int i = 0; i < ((len > D) ? D : len); i++) begin
                if ($urandom_range(0, 2) == 0) seq.push_back(16'($urandom_range(0, 31)) + 16'h100);
                if ($urandom_range(0, 11) != 0) seq.push_back(tbl_m[i]);
            end
            if ($urandom_range(0, 9) != 0) seq.push_back(ENC);
            model(seq, len, ph, k);
            mp0 = mp_total;
            do_arm(len);
            foreach (seq[i]) drv(seq[i]);
            chk_i = 16'h0; tick(); #6;
            chk("rand_idx", 32'(idx), 32'(k));
            chk("rand_matches", 32'(mp_total - mp0), 32'(k));
            chk("rand_flags", {done, pass, fail, busy}, {ph == 3, ph == 3, 1'b0, ph != 3});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
